// File: rtl/uart_fifo_xcvr.sv
// UART transmitter and receiver; received words land in a first-word-fall-through FIFO with sticky error flags.
// Optional feature: define UART_PARITY_EN for one parity bit per frame (polarity from PARITY_ODD).
module uart_fifo_xcvr #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic                        i_Tx_DV,
    input  logic [DATA_BITS-1:0]        i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Serial,
    input  logic                        i_Rx_Serial,
    input  logic                        i_Rx_Rd,
    output logic [DATA_BITS-1:0]        o_Rx_Byte,
    output logic                        o_Rx_Empty,
    output logic                        o_Rx_Full,
    output logic [$clog2(FIFO_DEPTH):0] o_Rx_Count,
    input  logic                        i_Err_Clr,
    output logic                        o_Rx_Overrun,
    output logic                        o_Rx_Frame_Err,
    output logic                        o_Rx_Parity_Err
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PARITY_ODD[0];
    endfunction
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               tx_state;
    logic [15:0]          tx_cnt;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    always_ff @(posedge i_Clock) begin
        if (tx_state == IDLE && i_Tx_DV && o_Tx_Ready) begin
            tx_shift <= i_Tx_Byte;
`ifdef UART_PARITY_EN
            tx_par   <= par_of(i_Tx_Byte);
`endif
        end else if ((tx_state == START || tx_state == DATA) && tx_cnt == BIT_LAST) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_state    <= IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Ready  <= 1'b1;
            o_Tx_Active <= 1'b0;
        end else if (tx_state == IDLE) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            if (i_Tx_DV && o_Tx_Ready) begin
                tx_state    <= START;
                o_Tx_Serial <= 1'b0;
                o_Tx_Ready  <= 1'b0;
                o_Tx_Active <= 1'b1;
            end
        end else if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 16'd1;
        end else begin
            // bit boundary: tx_shift[0] already holds the next data bit
            tx_cnt <= '0;
            if (tx_state == START) begin
                tx_state    <= DATA;
                o_Tx_Serial <= tx_shift[0];
            end else if (tx_state == DATA) begin
                if (tx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    tx_state    <= PARITY;
                    o_Tx_Serial <= tx_par;
`else
                    tx_state    <= STOP;
                    o_Tx_Serial <= 1'b1;
`endif
                end else begin
                    tx_bit      <= tx_bit + 4'd1;
                    o_Tx_Serial <= tx_shift[0];
                end
`ifdef UART_PARITY_EN
            end else if (tx_state == PARITY) begin
                tx_state    <= STOP;
                o_Tx_Serial <= 1'b1;
`endif
            end else begin
                tx_state    <= IDLE;
                o_Tx_Ready  <= 1'b1;
                o_Tx_Active <= 1'b0;
            end
        end
    end

    logic                 rx_sync_p0, rx_sync_p1;
    state_t               rx_state;
    logic [15:0]          rx_cnt;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_hold, rx_push, rx_fe_p;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad, rx_pe_p;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= i_Rx_Serial;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (rx_state == DATA && rx_cnt == BIT_LAST)
            rx_shift <= {rx_sync_p1, rx_shift[DATA_BITS-1:1]};
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_hold  <= 1'b0;
            rx_push  <= 1'b0;
            rx_fe_p  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
            rx_pe_p    <= 1'b0;
`endif
        end else begin
            rx_push <= 1'b0;
            rx_fe_p <= 1'b0;
`ifdef UART_PARITY_EN
            rx_pe_p <= 1'b0;
`endif
            case (rx_state)
                IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
`ifdef UART_PARITY_EN
                    rx_par_bad <= 1'b0;
`endif
                    // after a framing error the line must return high before a new start counts
                    if (rx_sync_p1)    rx_hold  <= 1'b0;
                    else if (!rx_hold) rx_state <= START;
                end
                START: begin
                    if (rx_cnt != HALF_LAST) begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end else begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync_p1 ? IDLE : DATA;
                    end
                end
                default: begin
                    if (rx_cnt != BIT_LAST) begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end else begin
                        rx_cnt <= '0;
                        if (rx_state == DATA) begin
                            if (rx_bit == DATA_LAST)
`ifdef UART_PARITY_EN
                                rx_state <= PARITY;
`else
                                rx_state <= STOP;
`endif
                            else
                                rx_bit <= rx_bit + 4'd1;
`ifdef UART_PARITY_EN
                        end else if (rx_state == PARITY) begin
                            rx_par_bad <= (rx_sync_p1 != par_of(rx_shift));
                            rx_state   <= STOP;
`endif
                        end else begin
                            rx_state <= IDLE;
                            if (!rx_sync_p1) begin
                                rx_fe_p <= 1'b1;
                                rx_hold <= 1'b1;
                            end
`ifdef UART_PARITY_EN
                            else if (rx_par_bad) rx_pe_p <= 1'b1;
`endif
                            else rx_push <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 do_push, do_pop;

    assign do_pop     = i_Rx_Rd && !o_Rx_Empty;
    assign do_push    = rx_push && (!o_Rx_Full || do_pop);
    assign o_Rx_Empty = (o_Rx_Count == '0);
    assign o_Rx_Full  = (o_Rx_Count == DEPTH_C);
    assign o_Rx_Byte  = o_Rx_Empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (do_push) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_Rx_Count     <= '0;
            o_Rx_Overrun   <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   o_Rx_Count <= o_Rx_Count + (AW+1)'(1);
                2'b01:   o_Rx_Count <= o_Rx_Count - (AW+1)'(1);
                default: o_Rx_Count <= o_Rx_Count;
            endcase
            // a same-cycle error event overrides the clear
            o_Rx_Overrun   <= (o_Rx_Overrun & ~i_Err_Clr) | (rx_push & o_Rx_Full & ~do_pop);
            o_Rx_Frame_Err <= (o_Rx_Frame_Err & ~i_Err_Clr) | rx_fe_p;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) o_Rx_Parity_Err <= 1'b0;
        else          o_Rx_Parity_Err <= (o_Rx_Parity_Err & ~i_Err_Clr) | rx_pe_p;
    end
`else
    assign o_Rx_Parity_Err = PARITY_ODD[0] & 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_xcvr.sv
// Scoreboard bench for uart_fifo_xcvr: line-level TX decoder, RX FIFO drain monitor, queue-based reference model.
`timescale 1ns/1ps
module tb_uart_fifo_xcvr;
    localparam int CPB   = 87;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int PODD  = 0;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = DB + 3;
`else
    localparam int FRAME_BITS = DB + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_dv = 1'b0;
    logic [DB-1:0] tx_byte = '0;
    logic rx_drv = 1'b1;
    logic lb = 1'b0;
    logic rd_mon = 1'b0;
    logic rd_tst = 1'b0;
    logic err_clr = 1'b0;
    logic tx_ready, tx_active, tx_serial;
    logic [DB-1:0] rx_byte;
    logic rx_empty, rx_full, ovr, fe, pe;
    logic [$clog2(DEPTH):0] rx_count;
    logic rx_line, rx_rd;

    assign rx_line = lb ? tx_serial : rx_drv;
    assign rx_rd   = rd_mon | rd_tst;

    uart_fifo_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(tx_ready), .o_Tx_Active(tx_active), .o_Tx_Serial(tx_serial),
        .i_Rx_Serial(rx_line), .i_Rx_Rd(rx_rd), .o_Rx_Byte(rx_byte),
        .o_Rx_Empty(rx_empty), .o_Rx_Full(rx_full), .o_Rx_Count(rx_count),
        .i_Err_Clr(err_clr), .o_Rx_Overrun(ovr), .o_Rx_Frame_Err(fe), .o_Rx_Parity_Err(pe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int epoch = 0;
    bit drain = 1'b0;
    bit exp_ovr = 1'b0, exp_fe = 1'b0, exp_pe = 1'b0;
    logic [DB-1:0] rx_q[$];
    logic [DB-1:0] tx_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic par_bit(input logic [DB-1:0] w);
        return logic'(($countones(w) + PODD) % 2);
    endfunction

    task automatic model_push(input logic [DB-1:0] w);
        if (rx_q.size() < DEPTH) rx_q.push_back(w);
        else exp_ovr = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("tx_ready_timeout", int'(tx_ready), 1);
    endtask

    task automatic tx_send(input logic [DB-1:0] w);
        wait_ready();
        tx_byte = w;
        tx_dv = 1'b1;
        tx_q.push_back(w);
        if (lb) model_push(w);
        @(negedge clk);
        tx_dv = 1'b0;
    endtask

    task automatic tx_timed(input logic [DB-1:0] w);
        int n = 0;
        wait_ready();
        tx_byte = w;
        tx_dv = 1'b1;
        tx_q.push_back(w);
        @(posedge clk);
        #1 tx_dv = 1'b0;
        chk("tx_start_low", int'(tx_serial), 0);
        chk("tx_ready_drop", int'(tx_ready), 0);
        chk("tx_active_rise", int'(tx_active), 1);
        while (n < 5000) begin
            @(posedge clk);
            n++;
            #1;
            if (tx_ready) break;
        end
        chk("tx_frame_len", n, FRAME_BITS * CPB);
        chk("tx_active_fall", int'(tx_active), 0);
    endtask

    task automatic rx_frame(input logic [DB-1:0] w, input bit bad_stop, input bit bad_par);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_drv = w[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = par_bit(w) ^ bad_par;
        repeat (CPB) @(negedge clk);
`endif
        if (bad_stop)     exp_fe = 1'b1;
        else if (bad_par) exp_pe = 1'b1;
        else              model_push(w);
        rx_drv = ~bad_stop;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        if (bad_stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic err_pulse();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        exp_pe  = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!(rx_empty && !rd_mon) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rx_drained", int'(rx_empty), 1);
        chk("rx_model_left", rx_q.size(), 0);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_overrun"}, int'(ovr), int'(exp_ovr));
        chk({tag, "_frame_err"}, int'(fe), int'(exp_fe));
        chk({tag, "_parity_err"}, int'(pe), int'(exp_pe));
    endtask

    // RX monitor: pops the FIFO head whenever draining is enabled and compares to the model
    initial begin
        forever begin
            @(negedge clk);
            if (drain && rst_n && !rx_empty) begin
                if (rx_q.size() == 0) chk("rx_unexpected_word", int'(rx_byte), -1);
                else                  chk("rx_word", int'(rx_byte), int'(rx_q.pop_front()));
                rd_mon = 1'b1;
                @(negedge clk);
                rd_mon = 1'b0;
            end
        end
    end

    // TX monitor: decodes the serial line at bit centres
    initial begin : tx_mon
        logic prev, st, sp, p;
        logic [DB-1:0] w, ew;
        int ep;
        prev = 1'b1;
        p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !tx_serial) begin
                ep = epoch;
                repeat (CPB / 2) @(negedge clk);
                st = tx_serial;
                for (int i = 0; i < DB; i++) begin
                    repeat (CPB) @(negedge clk);
                    w[i] = tx_serial;
                end
`ifdef UART_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = tx_serial;
`endif
                repeat (CPB) @(negedge clk);
                sp = tx_serial;
                if (ep == epoch) begin
                    chk("tx_start_bit", int'(st), 0);
                    if (tx_q.size() == 0) begin
                        chk("tx_unexpected_word", int'(w), -1);
                    end else begin
                        ew = tx_q.pop_front();
                        chk("tx_word", int'(w), int'(ew));
`ifdef UART_PARITY_EN
                        chk("tx_parity_bit", int'(p), int'(par_bit(ew)));
`endif
                    end
                    chk("tx_stop_bit", int'(sp), 1);
                end
            end
            prev = tx_serial;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit bs;
        repeat (3) @(negedge clk);
        chk("rst_tx_serial", int'(tx_serial), 1);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_tx_active", int'(tx_active), 0);
        chk("rst_rx_empty", int'(rx_empty), 1);
        chk("rst_rx_full", int'(rx_full), 0);
        chk("rst_rx_count", int'(rx_count), 0);
        chk("rst_rx_byte", int'(rx_byte), 0);
        chk_flags("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single TX word with exact frame timing
        tx_timed(8'hA5);
        repeat (CPB) @(negedge clk);

        // loopback, two words back to back
        lb = 1'b1;
        drain = 1'b0;
        tx_send(8'h3F);
        tx_send(8'hC0);
        wait_ready();
        repeat (CPB) @(negedge clk);
        chk("lb_count", int'(rx_count), rx_q.size());
        chk("lb_head", int'(rx_byte), int'(rx_q[0]));
        chk_flags("lb");
        drain = 1'b1;
        wait_empty();
        lb = 1'b0;

        // empty-FIFO reads are ignored
        @(negedge clk);
        rd_tst = 1'b1;
        repeat (3) @(negedge clk);
        rd_tst = 1'b0;
        @(negedge clk);
        chk("empty_rd_count", int'(rx_count), 0);
        chk("empty_rd_empty", int'(rx_empty), 1);

        // overflow: DEPTH+1 words with no reads
        drain = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) rx_frame(DB'(i), 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("ovf_full", int'(rx_full), 1);
        chk("ovf_count", int'(rx_count), rx_q.size());
        chk("ovf_head", int'(rx_byte), int'(rx_q[0]));
        chk_flags("ovf");
        drain = 1'b1;
        wait_empty();
        err_pulse();
        chk_flags("ovf_clr");

        // short glitch, then a frame with a low stop bit
        rx_drv = 1'b0;
        repeat (40) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_count", int'(rx_count), 0);
        chk_flags("glitch");
        rx_frame(8'h55, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("fe_count", int'(rx_count), 0);
        chk_flags("fe");
        err_pulse();
        chk_flags("fe_clr");
        rx_frame(8'h96, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        wait_empty();

`ifdef UART_PARITY_EN
        rx_frame(8'h07, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("pe_count", int'(rx_count), 0);
        chk_flags("pe");
        err_pulse();
        chk_flags("pe_clr");
`endif

        // randomized loopback traffic
        lb = 1'b1;
        for (int i = 0; i < 6; i++) tx_send(DB'($urandom));
        wait_ready();
        repeat (CPB) @(negedge clk);
        wait_empty();
        lb = 1'b0;

        // randomized direct RX frames with occasional framing errors
        for (int i = 0; i < 8; i++) begin
            bs = ($urandom_range(0, 3) == 0);
            rx_frame(DB'($urandom), bs, 1'b0);
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk_flags("rand");
        wait_empty();
        err_pulse();

        // reset in the middle of a TX frame and an RX frame
        tx_send(8'h00);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_drv = ~rx_drv;
            repeat (CPB) @(negedge clk);
        end
        chk("mid_tx_line", int'(tx_serial), 0);
        chk("mid_tx_active", int'(tx_active), 1);
        epoch++;
        tx_q.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_tx_serial", int'(tx_serial), 1);
        chk("arst_tx_ready", int'(tx_ready), 1);
        chk("arst_tx_active", int'(tx_active), 0);
        chk("arst_rx_empty", int'(rx_empty), 1);
        rx_drv = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME_BITS * CPB) @(negedge clk);
        chk("post_rst_count", int'(rx_count), 0);
        chk("post_rst_empty", int'(rx_empty), 1);
        chk("post_rst_line", int'(tx_serial), 1);
        chk_flags("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
